fp_normalizer: RTL and testbench

- Iterative post-add normalization stage of the vector FP32 datapath.
- Sits between the mantissa adder and the rounding stage. It accepts a raw signed sum (carry, hidden bit, fraction, two guard bits) plus a biased exponent.
- Produces a normalized {exponent, fraction} word, two guard bits, sign and rounding code, all in the format the rounding stage consumes.
- Right shift on carry takes one cycle; left shift is one bit per cycle under an FSM with a valid/ready handshake on both sides.

---
 rtl/fp_normalizer.sv | 168 ++++++++++++++++
 tb/tb_fp_normalizer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization for the FP32 vector datapath.
// A carry out of the adder is fixed by one right shift. A sum whose hidden
// bit is clear is shifted left one bit per cycle until the hidden bit is set
// or the exponent reaches zero. Handshakes are valid/ready on both sides, and
// only one operand is in flight at a time.
module fp_normalizer #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int CNT_W  = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     sign_i,
  input  logic [EXP_W-1:0]         exp_i,
  input  logic [FRAC_W+3:0]        mant_i,
  input  logic [1:0]               rm_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+FRAC_W-1:0]  value_o,
  output logic [1:0]               guard_o,
  output logic                     sign_o,
  output logic [1:0]               rm_o,
  output logic                     zero_o,
  output logic                     unf_o,
  output logic                     ovf_o,
  output logic [CNT_W-1:0]         shift_cnt_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                sign_reg;
  logic [1:0]          rm_reg;
  logic                hidden_reg;
  logic [EXP_W-1:0]    exp_reg;
  logic [FRAC_W-1:0]   frac_reg;
  logic [1:0]          guard_reg;
  logic                zero_reg;
  logic                unf_reg;
  logic                ovf_reg;
  logic [CNT_W-1:0]    shift_cnt_reg;

  // Field split of the raw adder sum.
  logic                mant_carry;
  logic                mant_hidden;
  logic [FRAC_W-1:0]   mant_frac;
  logic [1:0]          mant_guard;
  logic [EXP_W:0]      exp_inc;

  assign mant_carry  = mant_i[FRAC_W+3];
  assign mant_hidden = mant_i[FRAC_W+2];
  assign mant_frac   = mant_i[FRAC_W+1:2];
  assign mant_guard  = mant_i[1:0];

  // One extra bit so the increment's carry-out flags an exponent that was
  // already all-ones; in that case the exponent saturates instead of wrapping.
  assign exp_inc = {1'b0, exp_i} + {{EXP_W{1'b0}}, 1'b1};

  // Control FSM and working registers. Every output is taken directly from
  // a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      sign_reg      <= 1'b0;
      rm_reg        <= 2'b00;
      hidden_reg    <= 1'b0;
      exp_reg       <= '0;
      frac_reg      <= '0;
      guard_reg     <= 2'b00;
      zero_reg      <= 1'b0;
      unf_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      shift_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            sign_reg      <= sign_i;
            rm_reg        <= rm_i;
            shift_cnt_reg <= '0;
            zero_reg      <= 1'b0;
            unf_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            if (mant_i == '0) begin
              hidden_reg    <= 1'b0;
              exp_reg       <= '0;
              frac_reg      <= '0;
              guard_reg     <= 2'b00;
              zero_reg      <= 1'b1;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else if (mant_carry) begin
              // The bit shifted out of the fraction becomes the round bit.
              // The old round and sticky bits fold into sticky.
              hidden_reg    <= 1'b1;
              frac_reg      <= {mant_hidden, mant_frac[FRAC_W-1:1]};
              guard_reg     <= {mant_frac[0], |mant_guard};
              if (exp_inc[EXP_W]) begin
                exp_reg <= exp_i;
                ovf_reg <= 1'b1;
              end else begin
                exp_reg <= exp_inc[EXP_W-1:0];
              end
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              hidden_reg    <= mant_hidden;
              exp_reg       <= exp_i;
              frac_reg      <= mant_frac;
              guard_reg     <= mant_guard;
              state_reg     <= mant_hidden ? DONE : SHIFT;
              out_valid_reg <= mant_hidden;
            end
          end
        end
        SHIFT: begin
          if (hidden_reg) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else if (exp_reg == '0) begin
            // Denormal: stop without shifting. This cycle is included in
            // the latency.
            unf_reg       <= 1'b1;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            // Sticky is not shifted. Only the round bit moves up into the
            // fraction.
            {hidden_reg, frac_reg, guard_reg[1]} <= {frac_reg, guard_reg[1], 1'b0};
            exp_reg       <= exp_reg - {{(EXP_W-1){1'b0}}, 1'b1};
            shift_cnt_reg <= shift_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign value_o     = {exp_reg, frac_reg};
  assign guard_o     = guard_reg;
  assign sign_o      = sign_reg;
  assign rm_o        = rm_reg;
  assign zero_o      = zero_reg;
  assign unf_o       = unf_reg;
  assign ovf_o       = ovf_reg;
  assign shift_cnt_o = shift_cnt_reg;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed vectors with hand-computed expected results.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [26:0] mant_in = '0;
  logic [1:0]  rm_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] value;
  logic [1:0]  guard;
  logic        sign_out;
  logic [1:0]  rm_out;
  logic        zero;
  logic        unf;
  logic        ovf;
  logic [4:0]  shift_cnt;

  int checks_total = 0;
  int checks_passed = 0;

  fp_normalizer #(.EXP_W(8), .FRAC_W(23), .CNT_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sign_i      (sign_in),
    .exp_i       (exp_in),
    .mant_i      (mant_in),
    .rm_i        (rm_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .value_o     (value),
    .guard_o     (guard),
    .sign_o      (sign_out),
    .rm_o        (rm_out),
    .zero_o      (zero),
    .unf_o       (unf),
    .ovf_o       (ovf),
    .shift_cnt_o (shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand with out_ready held high. Latency is counted so that an
  // operand finishing on the accept edge reports 1.
  task automatic do_op(input string tag, input logic [7:0] e, input logic [26:0] m,
                       input logic s, input logic [1:0] r,
                       input logic [30:0] ev, input logic [1:0] eg, input logic [4:0] ecnt,
                       input logic [2:0] eflags, input int elat);
    int lat;
    sign_in = s; exp_in = e; mant_in = m; rm_in = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " value"}, 64'(value), 64'(ev));
    check({tag, " guard"}, 64'(guard), 64'(eg));
    check({tag, " shift_cnt"}, 64'(shift_cnt), 64'(ecnt));
    check({tag, " zero/unf/ovf"}, 64'({zero, unf, ovf}), 64'(eflags));
    check({tag, " sign/rm"}, 64'({sign_out, rm_out}), 64'({s, r}));
    $display("op %s: exp_i=%h mant_i=%h -> value=%h guard=%b cnt=%0d flags=%b lat=%0d",
             tag, e, m, value, guard, shift_cnt, {zero, unf, ovf}, lat);
    tick();
    check({tag, " back to idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int guard_cnt;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset outputs", 64'({value, guard, sign_out, rm_out, zero, unf, ovf, shift_cnt}), 64'd0);
    $display("reset: in_ready=%b out_valid=%b value=%h", in_ready, out_valid, value);

    // Carry: 11.000 x 2^0 with guard 11 -> 1.1 x 2^1, so the fraction MSB is
    // set. The round bit is the old frac[0]=0, and sticky = 1|1.
    do_op("carry", 8'h7F, 27'h6000003, 1'b0, 2'b01, 31'h40400000, 2'b01, 5'd0, 3'b000, 1);
    // Leading one at bit 23 takes two left shifts; the exponent drops by two.
    do_op("left2", 8'h85, 27'h0800000, 1'b1, 2'b10, 31'h41800000, 2'b00, 5'd2, 3'b000, 4);
    // The exponent reaches 0 after two shifts; the stop cycle flags unf.
    do_op("unf", 8'h02, 27'h0000004, 1'b0, 2'b11, 31'h00000004, 2'b00, 5'd2, 3'b010, 4);
    do_op("zero", 8'h55, 27'h0000000, 1'b1, 2'b00, 31'h00000000, 2'b00, 5'd0, 3'b100, 1);
    do_op("ovf", 8'hFF, 27'h4000000, 1'b0, 2'b01, 31'h7F800000, 2'b00, 5'd0, 3'b001, 1);
    do_op("norm", 8'h10, 27'h2000001, 1'b1, 2'b11, 31'h08000000, 2'b01, 5'd0, 3'b000, 1);
    // One left shift: the round bit moves into frac[0] and sticky stays put.
    do_op("left1g", 8'h40, 27'h1000003, 1'b0, 2'b01, 31'h1F800001, 2'b01, 5'd1, 3'b000, 3);
    // 0xFE + 1 reaches all-ones without overflowing.
    do_op("carry_fe", 8'hFE, 27'h4000002, 1'b0, 2'b00, 31'h7F800000, 2'b01, 5'd0, 3'b000, 1);

    // Reset while shifting.
    sign_in = 1'b1; exp_in = 8'h80; mant_in = 27'h0000010; rm_in = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("shift in_ready low", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset outputs", 64'({value, guard, sign_out, rm_out, zero, unf, ovf, shift_cnt}), 64'd0);
    $display("mid-shift reset: in_ready=%b out_valid=%b value=%h", in_ready, out_valid, value);

    // Backpressure: the result is held while out_ready is low and a
    // waiting operand is ignored.
    out_ready = 1'b0;
    sign_in = 1'b0; exp_in = 8'h85; mant_in = 27'h0800000; rm_in = 2'b01; in_valid = 1'b1;
    tick();
    sign_in = 1'b1; exp_in = 8'h10; mant_in = 27'h2000001; rm_in = 2'b11;
    guard_cnt = 0;
    while (!out_valid && guard_cnt < 40) begin
      tick();
      guard_cnt++;
    end
    check("bp valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp hold%0d", i),
            64'({out_valid, in_ready, value, guard, sign_out, rm_out, shift_cnt}),
            64'({1'b1, 1'b0, 31'h41800000, 2'b00, 1'b0, 2'b01, 5'd2}));
    end
    $display("backpressure: held value=%h in_ready=%b", value, in_ready);
    out_ready = 1'b1;
    tick();
    check("bp release", 64'({in_ready, out_valid}), 64'b10);
    tick();
    in_valid = 1'b0;
    check("bp next accept", 64'({out_valid, value, guard, sign_out, rm_out}),
          64'({1'b1, 31'h08000000, 2'b01, 1'b1, 2'b11}));
    $display("backpressure: next operand value=%h out_valid=%b", value, out_valid);
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
